// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: lock state encoding, default starvation limit and saturating increment
package dmem_arbiter_pkg;
  localparam logic RUN = 1'b0;
  localparam logic LOCKED = 1'b1;
  localparam int STARVE_LIMIT_DEF = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return v >= max ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// dmem_arbiter_sat_counter: counter with clear priority, saturating at MAX
module dmem_arbiter_sat_counter import dmem_arbiter_pkg::*; #(
  parameter int W = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= W'(sat_inc(32'(q), 32'(MAX)));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the core and a host, with starvation guard and host lock
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic          core_hold,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          lock_req,
  output logic          lock_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] cnt_core,
  output logic [CW-1:0] cnt_host,
  output logic [CW-1:0] cnt_stall
);
  logic          r_state;
  logic          r_host_rvalid;
  logic [DW-1:0] r_host_rdata;
  logic [7:0]    w_starve;
  logic          w_locked, w_gnt_host, w_gnt_core;
  assign w_locked   = r_state == LOCKED;
  assign w_gnt_host = !rst && host_valid && (w_locked || !core_req || w_starve == 8'(STARVE_LIMIT));
  assign w_gnt_core = !rst && core_req && !w_gnt_host && !w_locked;
  assign core_stall = !rst && core_req && !w_gnt_core;
  assign core_hold  = w_locked;
  assign lock_ack   = w_locked;
  assign host_ready = w_gnt_host;
  assign mem_en     = w_gnt_host || w_gnt_core;
  assign mem_we     = w_gnt_host ? host_we : w_gnt_core && core_we;
  assign mem_addr   = w_gnt_host ? host_addr : w_gnt_core ? core_addr : '0;
  assign mem_wdata  = w_gnt_host ? host_wdata : w_gnt_core ? core_wdata : '0;
  assign core_rdata = w_gnt_core ? mem_rdata : '0;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= RUN;
    else r_state <= lock_req ? LOCKED : RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= w_gnt_host && !host_we;
      if (w_gnt_host && !host_we) r_host_rdata <= mem_rdata;
    end
  dmem_arbiter_sat_counter #(.W(8), .MAX(8'(STARVE_LIMIT))) u_starve (
    .clk(clk), .rst(rst), .inc(1'b1), .clr(w_gnt_host || !host_valid), .q(w_starve));
  dmem_arbiter_sat_counter #(.W(CW)) u_cnt_core (
    .clk(clk), .rst(rst), .inc(w_gnt_core), .clr(1'b0), .q(cnt_core));
  dmem_arbiter_sat_counter #(.W(CW)) u_cnt_host (
    .clk(clk), .rst(rst), .inc(w_gnt_host), .clr(1'b0), .q(cnt_host));
  dmem_arbiter_sat_counter #(.W(CW)) u_cnt_stall (
    .clk(clk), .rst(rst), .inc(core_stall), .clr(1'b0), .q(cnt_stall));
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle core's load/store path and a host port (test/loader agent).
- The host port preloads sort arrays and reads back results.
- The core normally has priority. A starvation counter guarantees the host a slot. A lock FSM lets the host freeze the core for bulk transfers.
- Sits between the core's data-memory interface and the Data memory instance. Exports stall/hold signals that gate the core's PC and register writes.

Parameters:
- AW, 32, address width (word address)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive denied host cycles before the host is forced a grant; legal range 1..255
- CW, 32, width of the saturating performance counters

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- core_req  in  1  core load/store this cycle
- core_we  in  1  1=store, 0=load
- core_addr  in  AW  core word address
- core_wdata  in  DW  store data
- core_rdata  out  DW  load data (combinational from mem_rdata)
- core_stall  out  1  core access not granted this cycle; core holds PC and suppresses writeback
- core_hold  out  1  core frozen by host lock
- host_valid  in  1  host request pending
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1=write, 0=read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_rvalid  out  1  registered read-data valid, one-cycle pulse
- host_rdata  out  DW  registered read data
- lock_req  in  1  host requests exclusive ownership
- lock_ack  out  1  lock held
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr
- cnt_core  out  CW  core grants
- cnt_host  out  CW  host grants
- cnt_stall  out  CW  cycles with core_stall=1

Behaviour:
- Lock FSM, states RUN and LOCKED:
  - RUN->LOCKED on posedge with lock_req=1.
  - LOCKED->RUN on posedge with lock_req=0.
  - lock_ack=1 and core_hold=1 iff state==LOCKED.
- Grant equations (combinational; all forced 0 while rst=1):
  - gnt_host = host_valid & (LOCKED | !core_req | starve_cnt==STARVE_LIMIT)
  - gnt_core = core_req & !gnt_host & !LOCKED
  - core_stall = core_req & !gnt_core
  - host_ready = gnt_host
- Memory mux:
  - mem_en = gnt_host | gnt_core.
  - mem_we/mem_addr/mem_wdata come from the granted side.
  - mem_en=0 drives mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rdata = mem_rdata when gnt_core, else 0.
- starve_cnt (registered, 8 bits):
  - Cleared on gnt_host or !host_valid.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - Result: at most STARVE_LIMIT consecutive denied host cycles; the forced grant lands on the (STARVE_LIMIT+1)th pending cycle.
- Host read pipeline:
  - On a cycle with gnt_host & !host_we: host_rdata<=mem_rdata and host_rvalid<=1 at the next posedge.
  - Otherwise host_rvalid<=0; host_rdata holds its last value.
  - Back-to-back host reads give back-to-back rvalid pulses.
- Host handshake: the host holds valid/we/addr/wdata stable until a cycle with host_ready=1. Changing them while stalled is a host protocol violation; the bench flags it.
- Performance counters: increment on gnt_core, gnt_host and core_stall respectively. They saturate at all-ones with no wrap.
- Simultaneous events:
  - Core and host both requesting with starve_cnt<STARVE_LIMIT: core wins.
  - lock_req rising while the core is mid-request: that cycle's grant is still evaluated in RUN; the lock takes effect next cycle.
  - Core requests while LOCKED: core_stall=1 and core_hold=1.
  - No access is ever dropped: a stalled core retries the same access.
- Reset (asynchronous, any time): state=RUN; starve_cnt=0; host_rvalid=0; host_rdata=0; counters=0. All combinational outputs read 0 while rst=1. An in-flight host read is discarded with no rvalid.

Decomposition:
- Shared package holds:
  - lock state encoding (RUN=1'b0, LOCKED=1'b1)
  - STARVE_LIMIT default constant
  - a sat_inc function for saturating counters
- One natural sub-module: sat_counter (width CW, inc, clr). It is instantiated three times for the perf counters and once at width 8 for starve_cnt.

Test Plan:
- Core only: core_req=1 store addr 5 data 0x2A, then load addr 5 → mem_we=1 then 0, core_rdata=0x2A, core_stall=0, cnt_core=2.
- Contention, STARVE_LIMIT=4: core_req=1 continuously, host_valid=1 read addr 3 (pre-written 0x77) → host denied 4 cycles; granted on the 5th with core_stall=1; host_rvalid=1 and host_rdata=0x77 the next cycle; cnt_stall=1.
- Idle-core grant: core_req=0, host writes addr 9 ← 0xDEAD → host_ready=1 same cycle; subsequent core load addr 9 returns 0xDEAD.
- Lock: lock_req=1, then 8 host writes to addrs 0..7 with core_req=1 throughout → lock_ack=1, core_hold=1, core_stall=1 every cycle, one host_ready per cycle, cnt_host=8. Release lock_req → RUN next cycle, core granted.
- Reset mid-read: host read granted, rst asserted before the next posedge → host_rvalid stays 0, counters=0, state=RUN, mem_en=0 while rst=1.
- Counter saturation (CW=4): 20 core grants → cnt_core stops at 15.
